// File: rtl/fifo_rd_framer.sv
// FIFO read-side framer: pops tagged words into a registered valid/ready
// stream and truncates frames longer than MAXLEN.
module fifo_rd_framer #(
  parameter int DWIDTH = 16,
  parameter int MAXLEN = 760,
  parameter int LWIDTH = 11
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              fifo_empty,
  input  logic [DWIDTH:0]   fifo_dout_comb,
  output logic              fifo_re,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              m_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       trunc_cnt
);

  typedef enum logic [1:0] {
    SOF  = 2'd0,
    MOF  = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam logic [LWIDTH-1:0] MAX_L = LWIDTH'(MAXLEN);

  state_e              state_q, state_d;
  logic [LWIDTH-1:0]   len_q, len_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic [15:0]         fcnt_q, fcnt_d;
  logic [15:0]         tcnt_q, tcnt_d;

  logic                slot_free;
  logic                rd_en;
  logic                pop;
  logic                tag;
  logic [LWIDTH-1:0]   len_inc;
  logic                at_max;

  assign slot_free = ~valid_q | m_ready;
  assign tag       = fifo_dout_comb[DWIDTH];
  assign len_inc   = len_q + 1'b1;
  assign at_max    = (len_inc == MAX_L);

  // The drop path ignores backpressure so the tail never blocks the FIFO.
  always_comb begin
    rd_en = 1'b0;
    unique case (state_q)
      SOF, MOF: rd_en = ~fifo_empty & slot_free;
      DROP:     rd_en = ~fifo_empty;
      default:  rd_en = 1'b0;
    endcase
  end

  assign pop     = rd_en & arst_n;
  assign fifo_re = pop;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = err_q;
    valid_d = valid_q;
    fcnt_d  = fcnt_q;
    tcnt_d  = tcnt_q;

    if (valid_q & m_ready & last_q) begin
      fcnt_d = fcnt_q + 16'd1;
    end

    if (state_q == DROP) begin
      if (pop & tag) begin
        state_d = SOF;
      end
      if (m_ready) begin
        valid_d = 1'b0;
      end
    end else if (pop) begin
      data_d  = fifo_dout_comb[DWIDTH-1:0];
      valid_d = 1'b1;
      len_d   = len_inc;
      if (tag) begin
        last_d  = 1'b1;
        err_d   = 1'b0;
        len_d   = '0;
        state_d = SOF;
      end else if (at_max) begin
        last_d  = 1'b1;
        err_d   = 1'b1;
        len_d   = '0;
        tcnt_d  = tcnt_q + 16'd1;
        state_d = DROP;
      end else begin
        last_d  = 1'b0;
        err_d   = 1'b0;
        state_d = MOF;
      end
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= SOF;
      len_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign m_data    = data_q;
  assign m_last    = last_q;
  assign m_err     = err_q;
  assign m_valid   = valid_q;
  assign frame_cnt = fcnt_q;
  assign trunc_cnt = tcnt_q;

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Bench for fifo_rd_framer: queue-based FIFO, frame-level reference
// model and accepted-beat scoreboard.
module tb_fifo_rd_framer;

  localparam int ML = 4;

  logic        clk;
  logic        arst_n;
  logic        fifo_empty;
  logic [16:0] fifo_dout_comb;
  logic        fifo_re;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_err;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] frame_cnt;
  logic [15:0] trunc_cnt;

  fifo_rd_framer #(
    .DWIDTH(16),
    .MAXLEN(ML),
    .LWIDTH(11)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .fifo_empty    (fifo_empty),
    .fifo_dout_comb(fifo_dout_comb),
    .fifo_re       (fifo_re),
    .m_data        (m_data),
    .m_last        (m_last),
    .m_err         (m_err),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .frame_cnt     (frame_cnt),
    .trunc_cnt     (trunc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [16:0] fq[$];
  logic [16:0] hist[$];
  logic [17:0] acc[$];

  // model: words popped of current input frame, output register, counts
  int          w = 0;
  bit          ev = 0;
  logic [15:0] ed = '0;
  bit          el = 0;
  bit          ee = 0;
  int          ef = 0;
  int          et = 0;

  task automatic push_frame(input int len, input logic [15:0] base);
    for (int i = 0; i < len; i++) begin
      logic [16:0] wd;
      wd = {(i == len - 1), 16'(base + 16'(i))};
      fq.push_back(wd);
      hist.push_back(wd);
    end
  endtask

  // Expected beat stream derived from the pushed words, compared with
  // the beats actually accepted downstream.
  function automatic int stream_diffs();
    int n = 0;
    int bad = 0;
    logic [17:0] e[$];
    foreach (hist[i]) begin
      bit tg;
      tg = hist[i][16];
      if (n < ML)
        e.push_back({tg || (n + 1 == ML),
                     !tg && (n + 1 == ML),
                     hist[i][15:0]});
      n = tg ? 0 : n + 1;
    end
    if (e.size() != acc.size()) bad++;
    foreach (e[i])
      if (i >= acc.size() || acc[i] !== e[i]) bad++;
    return bad;
  endfunction

  task automatic drive_cycle(input bit rdy);
    bit slot, drop, exp_re, tg;
    logic [16:0] wd;
    m_ready = rdy;
    fifo_empty = (fq.size() == 0);
    fifo_dout_comb = fifo_empty ? 17'h0 : fq[0];
    #1;
    slot = !ev || rdy;
    drop = (w >= ML);
    exp_re = !fifo_empty && (drop || slot);
    checks++;
    if (fifo_re !== exp_re) begin
      errors++;
      $display("FAIL fifo_re t=%0t got %b want %b",
               $time, fifo_re, exp_re);
    end
    if (ev && rdy) begin
      acc.push_back({m_last, m_err, m_data});
      if (el) ef++;
    end
    if (exp_re) begin
      wd = fq.pop_front();
      tg = wd[16];
      if (!drop) begin
        ev = 1;
        ed = wd[15:0];
        el = tg || (w + 1 == ML);
        ee = !tg && (w + 1 == ML);
        if (ee) et++;
      end else if (rdy) begin
        ev = 0;
      end
      w = tg ? 0 : w + 1;
    end else if (rdy) begin
      ev = 0;
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_valid !== ev) begin
      errors++;
      $display("FAIL m_valid t=%0t got %b want %b",
               $time, m_valid, ev);
    end
    if (ev) begin
      checks++;
      if ({m_data, m_last, m_err} !== {ed, el, ee}) begin
        errors++;
        $display("FAIL beat t=%0t got %h/%b/%b want %h/%b/%b",
                 $time, m_data, m_last, m_err, ed, el, ee);
      end
    end
    checks++;
    if (frame_cnt !== 16'(ef) || trunc_cnt !== 16'(et)) begin
      errors++;
      $display("FAIL counters t=%0t got %0d/%0d want %0d/%0d",
               $time, frame_cnt, trunc_cnt, ef, et);
    end
    @(negedge clk);
  endtask

  task automatic clear_stream();
    acc.delete();
    hist.delete();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({m_valid, m_data, m_last, m_err} !== 19'h0) begin
      errors++;
      $display("FAIL reset_out got %b/%h/%b/%b want 0",
               m_valid, m_data, m_last, m_err);
    end
    checks++;
    if (frame_cnt !== 16'h0 || trunc_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0",
               frame_cnt, trunc_cnt);
    end
    fifo_empty = 1'b0;
    fifo_dout_comb = 17'h1_0005;
    m_ready = 1'b1;
    #1;
    checks++;
    if (fifo_re !== 1'b0) begin
      errors++;
      $display("FAIL reset_re got %b want 0", fifo_re);
    end
    @(negedge clk);
    arst_n = 1'b1;
    fifo_empty = 1'b1;
  endtask

  task automatic test_basic();
    push_frame(4, 16'h0001);
    for (int i = 0; i < 7; i++) drive_cycle(1'b1);
    checks++;
    if (frame_cnt !== 16'd1 || trunc_cnt !== 16'd0) begin
      errors++;
      $display("FAIL basic_cnt got %0d/%0d want 1/0",
               frame_cnt, trunc_cnt);
    end
    checks++;
    if (stream_diffs() != 0) begin
      errors++;
      $display("FAIL basic_stream got %0d diffs want 0",
               stream_diffs());
    end
    clear_stream();
  endtask

  task automatic test_backpressure();
    push_frame(3, 16'h0001);
    drive_cycle(1'b1);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0);
    checks++;
    if (m_data !== 16'h0001 || fq.size() != 2) begin
      errors++;
      $display("FAIL bp_hold got %h left %0d want 0001 left 2",
               m_data, fq.size());
    end
    for (int i = 0; i < 5; i++) drive_cycle(1'b1);
    checks++;
    if (stream_diffs() != 0) begin
      errors++;
      $display("FAIL bp_stream got %0d diffs want 0",
               stream_diffs());
    end
    clear_stream();
  endtask

  task automatic test_truncation();
    int f0, t0;
    f0 = ef;
    t0 = et;
    push_frame(7, 16'h0011);
    push_frame(2, 16'h0021);
    for (int i = 0; i < 12; i++) drive_cycle(1'b1);
    checks++;
    if (trunc_cnt !== 16'(t0 + 1) || frame_cnt !== 16'(f0 + 2)) begin
      errors++;
      $display("FAIL trunc_cnt got %0d/%0d want %0d/%0d",
               frame_cnt, trunc_cnt, f0 + 2, t0 + 1);
    end
    checks++;
    if (stream_diffs() != 0) begin
      errors++;
      $display("FAIL trunc_stream got %0d diffs want 0",
               stream_diffs());
    end
    clear_stream();
  endtask

  task automatic test_boundary();
    int t0;
    t0 = et;
    push_frame(4, 16'h0031);
    push_frame(1, 16'h0041);
    for (int i = 0; i < 8; i++) drive_cycle(1'b1);
    checks++;
    if (trunc_cnt !== 16'(t0)) begin
      errors++;
      $display("FAIL bound_trunc got %0d want %0d", trunc_cnt, t0);
    end
    checks++;
    if (stream_diffs() != 0) begin
      errors++;
      $display("FAIL bound_stream got %0d diffs want 0",
               stream_diffs());
    end
    clear_stream();
  endtask

  task automatic test_drain_blocked();
    push_frame(7, 16'h0051);
    for (int i = 0; i < 4; i++) drive_cycle(1'b1);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0);
    checks++;
    if (fq.size() != 0) begin
      errors++;
      $display("FAIL drain_left got %0d want 0", fq.size());
    end
    checks++;
    if ({m_valid, m_last, m_err, m_data} !== {3'b111, 16'h0054}) begin
      errors++;
      $display("FAIL drain_beat got %b%b%b/%h want 111/0054",
               m_valid, m_last, m_err, m_data);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b1);
    checks++;
    if (stream_diffs() != 0) begin
      errors++;
      $display("FAIL drain_stream got %0d diffs want 0",
               stream_diffs());
    end
    clear_stream();
  endtask

  task automatic test_reset_mid();
    push_frame(5, 16'h0061);
    drive_cycle(1'b1);
    drive_cycle(1'b1);
    arst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_valid got %b want 0", m_valid);
    end
    checks++;
    if (frame_cnt !== 16'h0 || trunc_cnt !== 16'h0) begin
      errors++;
      $display("FAIL rmid_cnt got %0d/%0d want 0/0",
               frame_cnt, trunc_cnt);
    end
    w = 0;
    ev = 0;
    ed = '0;
    el = 0;
    ee = 0;
    ef = 0;
    et = 0;
    acc.delete();
    hist = fq;
    #3;
    arst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) drive_cycle(1'b1);
    checks++;
    if (frame_cnt !== 16'd1 || trunc_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rmid_after got %0d/%0d want 1/0",
               frame_cnt, trunc_cnt);
    end
    checks++;
    if (stream_diffs() != 0) begin
      errors++;
      $display("FAIL rmid_stream got %0d diffs want 0",
               stream_diffs());
    end
    clear_stream();
  endtask

  task automatic test_random();
    logic [16:0] pend[$];
    int n = 0;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(9, 1);
      for (int i = 0; i < len; i++)
        pend.push_back({(i == len - 1), 16'($urandom)});
    end
    while (pend.size() > 0 && n < 3000) begin
      if ($urandom_range(3) != 0) begin
        fq.push_back(pend[0]);
        hist.push_back(pend.pop_front());
      end
      drive_cycle($urandom_range(9) < 7);
      n++;
    end
    for (int i = 0; i < 40; i++) drive_cycle(1'b1);
    checks++;
    if (pend.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain got %0d/%0d left want 0/0",
               pend.size(), fq.size());
    end
    checks++;
    if (stream_diffs() != 0) begin
      errors++;
      $display("FAIL rnd_stream got %0d diffs want 0",
               stream_diffs());
    end
    clear_stream();
  endtask

  initial begin
    arst_n = 1'b0;
    m_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout_comb = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_truncation();
    test_boundary();
    test_drain_blocked();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
